fir_out_buffer: RTL
===================

# fir_out_buffer

Output-side collector for the FIR datapath. Captures each completed accumulator sum (2*WIDTH+6 bits, signed) on a one-cycle strobe from the filter controller. Scales it back to a WIDTH-bit signed sample by arithmetic right shift and saturation, and queues it in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8: sample width; input sum width is 2*WIDTH+6.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SHIFT, WIDTH-1: fractional bits dropped from the sum; 1 ≤ SHIFT ≤ 2*WIDTH+5.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  one-cycle strobe: in_data holds a finished sum.
- in_data  in  2*WIDTH+6  signed accumulator sum.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  WIDTH  signed scaled sample at FIFO head.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: at least one sample dropped.
- sat  out  1  sticky: at least one sample saturated.
- clr_flags  in  1  clears overflow and sat.

## Operation
- Scaling (combinational on in_data): s = in_data >>> SHIFT (arithmetic, floor).
  - s > 2^(WIDTH-1)-1 → 2^(WIDTH-1)-1, and sat set.
  - s < -2^(WIDTH-1) → -2^(WIDTH-1), and sat set.
  - Otherwise s[WIDTH-1:0].
- Pop: out_valid && out_ready. Advances rd_ptr.
- Push: in_valid && (!full || pop). Writes the scaled sample at wr_ptr and advances wr_ptr.
  - When full, a push in the same cycle as a pop is accepted.
- Drop: in_valid && full && !pop. The sample is discarded, overflow is set, and pointers and count are unchanged.
  - sat is still set if the dropped sample would have saturated.
- count changes as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid, else 0.
- clr_flags clears overflow and sat. A set event in the same cycle takes priority: the flag stays 1.
- Reset (rst=0 at an edge) has the following effect:
  - rd_ptr, wr_ptr, count, overflow and sat become 0.
  - out_valid and full become 0, and out_data becomes 0.
  - Memory contents are not reset.
  - Reset mid-stream discards all queued samples.
  - in_valid in a reset cycle is ignored.

## Timing
- Sample accepted at edge N → visible at head from cycle N+1 when the FIFO was empty.
  - out_valid rises in cycle N+1.
- Pop at edge M → next entry, or out_valid=0, from cycle M+1.
- Throughput: one push and one pop per cycle, sustained.
- out_data must be stable while out_valid=1 and out_ready=0.
- full, count and the flags are registered state; they update at the edge following the event.
- No combinational path from out_ready to out_valid. out_ready does combinationally affect push acceptance when full.

## Configuration
- Macro FIR_OUT_ROUND_EN.
  - Defined: round half-up before the shift, s = (in_data + 2^(SHIFT-1)) >>> SHIFT. The addition is carried one bit wider so it cannot wrap; saturation is then applied to the rounded value.
  - Undefined: plain truncation (floor) as above.
- No other behaviour changes.

## Test plan
All scenarios use WIDTH=8, SHIFT=7, DEPTH=4.
- Basic path: in_data=256, strobe, out_ready=0.
  - Next cycle: out_valid=1, out_data=2, count=1.
  - Raise out_ready for one cycle → out_valid=0, count=0.
- Saturation and sat flag:
  - in_data=1048575 → out_data=127, sat=1.
  - in_data=−20000 → out_data=−128.
  - clr_flags → sat=0.
- Rounding, with in_data=192 and in_data=−192:
  - Without FIR_OUT_ROUND_EN: 1 and −2.
  - With FIR_OUT_ROUND_EN: 2 and −1.
- Full / overflow and full with simultaneous pop:
  - Push 10, 20, 30, 40 (in_data=k*128), then push 50 with out_ready=0 → count=4, full=1, overflow=1.
  - Drain order is 10, 20, 30, 40.
  - Refill to full, then push 60 with out_ready=1 in the same cycle → accepted, count stays 4, overflow unchanged.
- Streaming: in_valid every cycle for 20 cycles with out_ready=1 → 20 outputs in order, each one cycle after input, count ≤1, overflow=0.
- Reset mid-operation: 3 entries queued, rst=0 for one cycle → count=0, out_valid=0, out_data=0, flags 0.
  - Next push appears as a fresh single entry.

Source files
------------

// File: rtl/fir_out_buffer_if.sv
// -----------------------------------------------------------------------------
// fir_out_buffer_if
//   Bundle of the capture, drain and status signals of fir_out_buffer.
//
//   Capture side : in_valid, in_data (2*WIDTH+6 bit signed sum), clr_flags
//   Drain side   : out_valid, out_ready, out_data (WIDTH bit signed sample)
//   Status       : count, full, overflow, sat
//
//   Modports:
//     master - the surroundings (filter controller, consumer, bench)
//     slave  - the fir_out_buffer itself
// -----------------------------------------------------------------------------
interface fir_out_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SW = 2 * WIDTH + 6;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic signed [SW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 overflow;
    logic                 sat;
    logic                 clr_flags;

    modport master (
        output in_valid, in_data, out_ready, clr_flags,
        input  out_valid, out_data, count, full, overflow, sat
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_flags,
        output out_valid, out_data, count, full, overflow, sat
    );
endinterface

// File: rtl/fir_out_buffer.sv
// -----------------------------------------------------------------------------
// fir_out_buffer
//   Captures finished FIR accumulator sums, scales them to WIDTH-bit signed
//   samples (arithmetic right shift by SHIFT, then saturation) and queues them
//   in a DEPTH-entry FIFO drained through a valid/ready handshake.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous, active-low reset
//     bus  - fir_out_buffer_if.slave:
//              in_valid/in_data   one-cycle strobe with the accumulator sum
//              out_valid/out_ready/out_data  FIFO head handshake
//              count, full        occupancy (registered)
//              overflow, sat      sticky flags, cleared by clr_flags
//
//   Configuration macro:
//     FIR_OUT_ROUND_EN - round half-up before the shift instead of flooring.
// -----------------------------------------------------------------------------
module fir_out_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SHIFT = WIDTH - 1
) (
    input logic            clk,
    input logic            rst,
    fir_out_buffer_if.slave bus
);
    localparam int SW = 2 * WIDTH + 6;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
    localparam logic signed [SW:0] SAT_MAX = (SW + 1)'((2 ** (WIDTH - 1)) - 1);
    // Bitwise inverse of the largest positive value is the most negative one.
    localparam logic signed [SW:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------ scale
    // One extra bit keeps the rounding addition from wrapping near full scale.
    logic signed [SW:0]  ext_sum;
    logic signed [SW:0]  shifted;
    logic [WIDTH-1:0]    scaled;
    logic                sat_hit;

`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [SW:0] HALF_LSB = (SW + 1)'(1) << (SHIFT - 1);
    assign ext_sum = {bus.in_data[SW-1], bus.in_data} + HALF_LSB;
`else
    assign ext_sum = {bus.in_data[SW-1], bus.in_data};
`endif

    assign shifted = ext_sum >>> SHIFT;

    // NOTE: every output of this block is given a default first so no
    // combination of branches can leave it unassigned and infer a latch.
    always_comb begin
        scaled  = shifted[WIDTH-1:0];
        sat_hit = 1'b0;
        if (shifted > SAT_MAX) begin
            scaled  = SAT_MAX[WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (shifted < SAT_MIN) begin
            scaled  = SAT_MIN[WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------- fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             sat_q;

    logic full_w;
    logic valid_w;
    logic pop;
    logic push;
    logic drop;

    assign full_w  = (count_q == DEPTH_C);
    assign valid_w = (count_q != '0);
    assign pop     = valid_w && bus.out_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign push    = bus.in_valid && (!full_w || pop);
    assign drop    = bus.in_valid && full_w && !pop;

    // NOTE: the sample storage has no reset; pointers and count define which
    // entries are live, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= scaled;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            // A set event wins over a simultaneous clear.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_flags) begin
                overflow_q <= 1'b0;
            end

            // Dropped samples still report saturation.
            if (bus.in_valid && sat_hit) begin
                sat_q <= 1'b1;
            end else if (bus.clr_flags) begin
                sat_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid_w;
    assign bus.out_data  = valid_w ? mem[rd_ptr] : '0;
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.overflow  = overflow_q;
    assign bus.sat       = sat_q;

endmodule
